midi_uart_arbiter: RTL and testbench

//  Shares the single MIDI UART transmitter between the pitch (note) and volume

---
 rtl/midi_uart_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_midi_uart_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_arbiter.sv
// Round-robin arbiter that streams whole MIDI messages from note/volume senders into one uart_tx.
// Optional running status (omit repeated status bytes) is enabled by defining MIDI_RUNNING_STATUS_EN.
`timescale 1ns/1ps
module midi_uart_arbiter #(
    parameter int BUSY_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [7:0] a_status,
    input  logic [7:0] a_data1,
    input  logic [7:0] a_data2,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_status,
    input  logic [7:0] b_data1,
    input  logic [7:0] b_data2,
    output logic       b_ready,
    output logic [7:0] midi_byte,
    output logic       midi_send,
    input  logic       uart_busy,
    output logic       busy,
    output logic       err_pulse
);

    localparam int CW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t         state_q, state_d;
    logic           grant_q, grant_d;          // 0 = A, 1 = B
    logic           last_grant_q, last_grant_d;
    logic [7:0]     status_q, status_d;
    logic [7:0]     data1_q, data1_d;
    logic [7:0]     data2_q, data2_d;
    logic [1:0]     idx_q, idx_d;
    logic [1:0]     last_idx_q, last_idx_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0]     last_status_q, last_status_d;
`endif

    logic [7:0] sel_status, sel_data1, sel_data2;
    logic [1:0] start_idx;

    assign sel_status = grant_q ? b_status : a_status;
    assign sel_data1  = grant_q ? b_data1  : a_data1;
    assign sel_data2  = grant_q ? b_data2  : a_data2;

`ifdef MIDI_RUNNING_STATUS_EN
    assign start_idx = (sel_status == last_status_q) ? 2'd1 : 2'd0;
`else
    assign start_idx = 2'd0;
`endif

    // Data bytes are stored with bit7 already cleared, so the byte mux is a plain select.
    always_comb begin
        case (idx_q)
            2'd0:    midi_byte = status_q;
            2'd1:    midi_byte = data1_q;
            default: midi_byte = data2_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        status_d     = status_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        idx_d        = idx_q;
        last_idx_d   = last_idx_q;
        wait_cnt_d   = wait_cnt_q;
`ifdef MIDI_RUNNING_STATUS_EN
        last_status_d = last_status_q;
`endif
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        midi_send = 1'b0;
        err_pulse = 1'b0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (a_valid && b_valid) begin
                    grant_d = ~last_grant_q;
                    state_d = S_CAPTURE;
                end else if (a_valid) begin
                    grant_d = 1'b0;
                    state_d = S_CAPTURE;
                end else if (b_valid) begin
                    grant_d = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                a_ready      = ~grant_q;
                b_ready      = grant_q;
                last_grant_d = grant_q;
                if (!sel_status[7]) begin
                    err_pulse = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    status_d   = sel_status;
                    data1_d    = {1'b0, sel_data1[6:0]};
                    data2_d    = {1'b0, sel_data2[6:0]};
                    idx_d      = start_idx;
                    last_idx_d = (sel_status[7:5] == 3'b110) ? 2'd1 : 2'd2;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                // Hold off the start pulse while the UART still reports busy.
                if (!uart_busy) begin
                    midi_send  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT_HI;
`ifdef MIDI_RUNNING_STATUS_EN
                    if (idx_q == 2'd0) last_status_d = status_q;
`endif
                end
            end
            S_WAIT_HI: begin
                if (uart_busy) begin
                    state_d = S_WAIT_LO;
                end else if (wait_cnt_q == CW'(BUSY_WAIT - 1)) begin
                    if (idx_q == last_idx_q) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_SEND;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!uart_busy) begin
                    if (idx_q == last_idx_q) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            status_q     <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            idx_q        <= '0;
            last_idx_q   <= '0;
            wait_cnt_q   <= '0;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            status_q     <= status_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            idx_q        <= idx_d;
            last_idx_q   <= last_idx_d;
            wait_cnt_q   <= wait_cnt_d;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status_q <= last_status_d;
`endif
        end
    end

endmodule

// File: tb/tb_midi_uart_arbiter.sv
// Directed bench for midi_uart_arbiter with a simple uart_tx busy model and a byte log.
`timescale 1ns/1ps
module tb_midi_uart_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid;
    logic [7:0] a_status, a_data1, a_data2;
    logic [7:0] b_status, b_data1, b_data2;
    logic       a_ready, b_ready;
    logic [7:0] midi_byte;
    logic       midi_send;
    logic       uart_busy = 1'b0;
    logic       busy, err_pulse;

    int total = 0;
    int bad   = 0;

    logic [7:0] log_q[$];
    logic [7:0] expq[$];
    int a_rdy_cnt = 0, b_rdy_cnt = 0, err_cnt = 0, viol_cnt = 0;
    logic uart_en = 1'b1;
    int   ucnt = 0;

    midi_uart_arbiter #(.BUSY_WAIT(16)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_status(a_status), .a_data1(a_data1), .a_data2(a_data2), .a_ready(a_ready),
        .b_valid(b_valid), .b_status(b_status), .b_data1(b_data1), .b_data2(b_data2), .b_ready(b_ready),
        .midi_byte(midi_byte), .midi_send(midi_send), .uart_busy(uart_busy),
        .busy(busy), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (midi_send) log_q.push_back(midi_byte);
            if (midi_send && uart_busy) viol_cnt++;
            if (a_ready) a_rdy_cnt++;
            if (b_ready) b_rdy_cnt++;
            if (err_pulse) err_cnt++;
        end
    end

    // uart_tx model: busy for 3 cycles after each start pulse.
    always @(posedge clk) begin
        if (!uart_en) begin
            ucnt      <= 0;
            uart_busy <= 1'b0;
        end else if (midi_send) begin
            ucnt      <= 3;
            uart_busy <= 1'b1;
        end else if (ucnt > 1) begin
            ucnt <= ucnt - 1;
        end else begin
            ucnt      <= 0;
            uart_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, log_q.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < log_q.size())
                chk($sformatf("%s_b%0d", tag, i), {24'd0, log_q[i]}, {24'd0, expq[i]});
        end
    endtask

    task automatic set_a(input logic v, input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
        a_valid = v; a_status = s; a_data1 = d1; a_data2 = d2;
    endtask

    task automatic set_b(input logic v, input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
        b_valid = v; b_status = s; b_data1 = d1; b_data2 = d2;
    endtask

    task automatic clear_logs();
        log_q.delete();
        a_rdy_cnt = 0; b_rdy_cnt = 0; err_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_rdy(input string tag, output logic ga, output logic gb);
        int n = 0;
        while (!(a_ready || b_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy_timeout"}, (n < 300), 1);
        ga = a_ready;
        gb = b_ready;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_timeout"}, (n < 500), 1);
    endtask

    task automatic wait_bytes(input string tag, input int cnt);
        int n = 0;
        while (log_q.size() < cnt && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_bytes_timeout"}, (n < 500), 1);
    endtask

    initial begin
        logic ga, gb;
        int   cyc;

        rst = 1'b1;
        set_a(0, 8'h00, 8'h00, 8'h00);
        set_b(0, 8'h00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_midi_send", midi_send, 0);
        chk("rst_midi_byte", midi_byte, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_pulse, 0);
        rst = 1'b0;
        clear_logs();
        @(negedge clk);

        // A alone; first midi_send two cycles after valid.
        set_a(1, 8'h90, 8'h3C, 8'h64);
        @(negedge clk);
        chk("t1_a_ready_lat", a_ready, 1);
        chk("t1_busy_cap", busy, 1);
        chk("t1_no_send_cap", midi_send, 0);
        @(negedge clk);
        chk("t1_send_lat", midi_send, 1);
        chk("t1_first_byte", midi_byte, 8'h90);
        set_a(0, 8'h00, 8'hFF, 8'hFF);
        wait_bytes("t1", 3);
        chk("t1_busy_mid", busy, 1);
        wait_idle("t1");
        expq = '{8'h90, 8'h3C, 8'h64};
        chk_log("t1");
        chk("t1_a_rdy_cnt", a_rdy_cnt, 1);

        // Tie after reset: A wins, then B wins the next tie against a re-requesting A.
        do_reset();
        set_a(1, 8'h90, 8'h3C, 8'h64);
        set_b(1, 8'hB0, 8'h07, 8'h50);
        wait_rdy("t2a", ga, gb);
        chk("t2_first_is_a", {ga, gb}, 2'b10);
        @(negedge clk);
        set_a(1, 8'h91, 8'h41, 8'h11);
        wait_rdy("t2b", ga, gb);
        chk("t2_second_is_b", {ga, gb}, 2'b01);
        @(negedge clk);
        b_valid = 1'b0;
        wait_rdy("t2c", ga, gb);
        chk("t2_third_is_a", {ga, gb}, 2'b10);
        @(negedge clk);
        a_valid = 1'b0;
        wait_idle("t2");
        expq = '{8'h90, 8'h3C, 8'h64, 8'hB0, 8'h07, 8'h50, 8'h91, 8'h41, 8'h11};
        chk_log("t2");

        // Two-byte program change with data bit7 set.
        clear_logs();
        set_b(1, 8'hC0, 8'h85, 8'h77);
        wait_rdy("t3", ga, gb);
        chk("t3_is_b", {ga, gb}, 2'b01);
        @(negedge clk);
        b_valid = 1'b0;
        wait_idle("t3");
        repeat (3) @(negedge clk);
        expq = '{8'hC0, 8'h05};
        chk_log("t3");

        // Invalid status byte: dropped with err_pulse, nothing sent.
        clear_logs();
        set_a(1, 8'h10, 8'h11, 8'h12);
        wait_rdy("t4", ga, gb);
        chk("t4_is_a", {ga, gb}, 2'b10);
        chk("t4_err_hi", err_pulse, 1);
        chk("t4_no_send", midi_send, 0);
        @(negedge clk);
        a_valid = 1'b0;
        chk("t4_idle", busy, 0);
        chk("t4_err_lo", err_pulse, 0);
        repeat (4) @(negedge clk);
        chk("t4_no_bytes", log_q.size(), 0);
        chk("t4_err_cnt", err_cnt, 1);

        // UART never reports busy: each byte times out after 16 cycles.
        uart_en = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        set_a(1, 8'h90, 8'h3C, 8'h64);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) a_valid = 1'b0;
        end while (busy && cyc < 300);
        chk("t5_cycles", cyc, 53);
        expq = '{8'h90, 8'h3C, 8'h64};
        chk_log("t5");
        uart_en = 1'b1;

        // Reset after the first byte abandons the rest.
        do_reset();
        set_a(1, 8'h90, 8'h3C, 8'h64);
        wait_rdy("t6", ga, gb);
        @(negedge clk);
        a_valid = 1'b0;
        wait_bytes("t6", 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_send", midi_send, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_byte", midi_byte, 8'h00);
        chk("t6_rst_ready", a_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_abandoned", log_q.size(), 1);
        chk("t6_one_ready", a_rdy_cnt, 1);
        set_a(1, 8'h90, 8'h3D, 8'h65);
        wait_rdy("t6b", ga, gb);
        @(negedge clk);
        a_valid = 1'b0;
        wait_idle("t6b");
        expq = '{8'h90, 8'h90, 8'h3D, 8'h65};
        chk_log("t6");

`ifdef MIDI_RUNNING_STATUS_EN
        do_reset();
        set_a(1, 8'h90, 8'h3C, 8'h64);
        wait_rdy("rs1", ga, gb);
        @(negedge clk);
        set_a(1, 8'h90, 8'h3E, 8'h64);
        wait_rdy("rs2", ga, gb);
        chk("rs_second_a", {ga, gb}, 2'b10);
        @(negedge clk);
        a_valid = 1'b0;
        wait_idle("rs");
        expq = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64};
        chk_log("rs");
`endif

        chk("send_while_busy", viol_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
